// File: rtl/bridge_pkg.sv
// Shared encodings for the AHB-to-APB bridge: FSM state codes, HTRANS and HRESP values.
package bridge_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic htrans_valid(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: the index field of the address selects one PSEL line,
// and an index with no matching slave raises the miss flag instead.
module apb_addr_decode #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_miss
);

  localparam int IDX_W = $clog2(NUM_SLAVES) + 1;

  logic [IDX_W-1:0] w_idx;
  logic             w_unused_addr;

  assign w_idx         = i_addr[SEL_LSB +: IDX_W];
  assign w_unused_addr = ^i_addr;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_sel  = '0;
    o_miss = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx == IDX_W'(i)) begin
        o_sel[i] = 1'b1;
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: N-way decode, PREADY wait states, PSLVERR/timeout
// error responses, and optional posted writes with a one-deep pending transfer.
module apb_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16,
  parameter int WRITE_POST = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_W-1:0]     HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [DATA_W-1:0]     HWDATA,
  input  logic                  HREADYin,
  output logic                  HREADYout,
  output logic                  HRESP,
  output logic [DATA_W-1:0]     HRDATA,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  post_err,
  input  logic                  post_err_clr
);

  localparam int                  TCNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0]   TCNT_MAX = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic                POSTING  = (WRITE_POST != 0);

  logic [2:0]            r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_write;
  logic [NUM_SLAVES-1:0] r_sel;
  logic                  r_miss;
  logic                  r_posted;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [TCNT_W-1:0]     r_tcnt;
  logic                  r_pend_valid;
  logic [ADDR_W-1:0]     r_pend_addr;
  logic                  r_pend_write;
  logic [NUM_SLAVES-1:0] r_pend_sel;
  logic                  r_pend_miss;
  logic                  r_post_err;

  logic [NUM_SLAVES-1:0] w_dec_sel;
  logic                  w_dec_miss;
  logic                  w_ready;
  logic                  w_resp;
  logic                  w_apb_act;
  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_fail;

  apb_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB)
  ) u_decode (
    .i_addr (HADDR),
    .o_sel  (w_dec_sel),
    .o_miss (w_dec_miss)
  );

  always_comb begin
    w_ready = 1'b1;
    w_resp  = HRESP_OKAY;
    case (r_state)
      ST_DATA:   w_ready = r_posted & ~r_miss;
      ST_SETUP,
      ST_ACCESS: w_ready = 1'b0;
      ST_ERR1: begin
        w_ready = 1'b0;
        w_resp  = HRESP_ERROR;
      end
      ST_ERR2:   w_resp  = HRESP_ERROR;
      default:   w_ready = 1'b1;
    endcase
  end

  // Only IDLE and a posted-write DATA phase may take a new address; ERR2 never does.
  assign w_accept  = HSEL & htrans_valid(HTRANS) & HREADYin & w_ready &
                     ((r_state == ST_IDLE) | (r_state == ST_DATA));
  assign w_apb_act = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
  assign w_timeout = (TIMEOUT != 0) && (r_tcnt == TCNT_MAX);
  assign w_done    = (r_state == ST_ACCESS) & PREADY;
  assign w_abort   = (r_state == ST_ACCESS) & ~PREADY & w_timeout;
  assign w_fail    = (w_done & PSLVERR) | w_abort;

  assign HREADYout = w_ready;
  assign HRESP     = w_resp;
  assign HRDATA    = r_rdata;
  assign PSEL      = w_apb_act ? r_sel : '0;
  assign PENABLE   = (r_state == ST_ACCESS);
  assign PADDR     = w_apb_act ? r_addr : '0;
  assign PWRITE    = w_apb_act & r_write;
  assign PWDATA    = w_apb_act ? r_wdata : '0;
  assign post_err  = r_post_err;

  // NOTE: state updates use non-blocking assignments; reset is synchronous and clears every register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_sel        <= '0;
      r_miss       <= 1'b0;
      r_posted     <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_tcnt       <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_write <= 1'b0;
      r_pend_sel   <= '0;
      r_pend_miss  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= HADDR;
            r_write  <= HWRITE;
            r_sel    <= w_dec_sel;
            r_miss   <= w_dec_miss;
            r_posted <= HWRITE & POSTING;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_write) r_wdata <= HWDATA;
          if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= HADDR;
            r_pend_write <= HWRITE;
            r_pend_sel   <= w_dec_sel;
            r_pend_miss  <= w_dec_miss;
          end
          r_state <= r_miss ? ST_ERR1 : ST_SETUP;
        end
        ST_SETUP: begin
          r_tcnt  <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_done | w_abort) begin
            if (w_done & ~PSLVERR & ~r_write) r_rdata <= PRDATA;
            // The pending transfer skips DATA: its write data is already on HWDATA,
            // and it always completes non-posted because its data phase is stalled.
            if (r_pend_valid) begin
              r_pend_valid <= 1'b0;
              r_addr       <= r_pend_addr;
              r_write      <= r_pend_write;
              r_sel        <= r_pend_sel;
              r_miss       <= r_pend_miss;
              r_posted     <= 1'b0;
              if (r_pend_write) r_wdata <= HWDATA;
              r_state      <= r_pend_miss ? ST_ERR1 : ST_SETUP;
            end else if (w_fail & ~r_posted) begin
              r_state <= ST_ERR1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Set has priority over clear so a failure in the clearing cycle is not lost.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_post_err <= 1'b0;
    end else if (w_fail & r_posted) begin
      r_post_err <= 1'b1;
    end else if (post_err_clr) begin
      r_post_err <= 1'b0;
    end
  end

endmodule
